dbus_ctrl: RTL and testbench

//  Memory-stage data-bus sequencer. Turns one M-stage load/store into a dbus

---
 rtl/dbus_ctrl_pkg.sv | 44 ++++
 rtl/dbus_ctrl_strobe_gen.sv | 37 +++
 rtl/dbus_ctrl.sv | 124 ++++++++++++
 tb/tb_dbus_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_ctrl_pkg.sv
`default_nettype none
//==============================================================================
// dbus_ctrl_pkg: shared dbus request/response types, access sizes, FSM states.
// Rev 1.0
//==============================================================================
package dbus_ctrl_pkg;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } dbus_state_t;

  function automatic logic is_misaligned(input msize_t size, input logic [1:0] lsb);
    case (size)
      MSIZE2:  return lsb[0];
      MSIZE4:  return |lsb;
      default: return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dbus_ctrl_strobe_gen.sv
`default_nettype none
//==============================================================================
// dbus_strobe_gen: byte-lane strobe and replicated store data for one access.
// Rev 1.0
//==============================================================================
module dbus_strobe_gen
  import dbus_ctrl_pkg::*;
(
  input  msize_t      size,
  input  logic [1:0]  addr_lo,
  input  logic        wr,
  input  logic [31:0] wdata,
  output logic [3:0]  strobe,
  output logic [31:0] data
);

  // Replicating the value puts it on whichever lane the strobe selects.
  always_comb begin
    strobe = 4'b0000;
    data   = wdata;
    case (size)
      MSIZE1: begin
        strobe = 4'b0001 << addr_lo;
        data   = {4{wdata[7:0]}};
      end
      MSIZE2: begin
        strobe = 4'b0011 << {addr_lo[1], 1'b0};
        data   = {2{wdata[15:0]}};
      end
      MSIZE4:  strobe = 4'b1111;
      default: strobe = 4'b0000;
    endcase
    if (!wr) strobe = 4'b0000;
  end

endmodule
`default_nettype wire

// File: rtl/dbus_ctrl.sv
`default_nettype none
//==============================================================================
// dbus_ctrl: M-stage data-bus sequencer; one load/store -> one dbus transaction.
// Rev 1.0
//==============================================================================
module dbus_ctrl
  import dbus_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_en,
  input  logic        mem_wr,
  input  logic [31:0] mem_addr,
  input  msize_t      mem_size,
  input  logic [31:0] mem_wdata,
  input  logic        advance,
  input  logic        flush,
  output dbus_req_t   dreq,
  input  dbus_resp_t  dresp,
  output logic        stall_mem,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        err_timeout
);

  localparam int              CNT_W     = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYC);

  dbus_state_t      state;
  logic             kill;
  logic [CNT_W-1:0] tmo_cnt;
  logic [3:0]       gen_strobe;
  logic [31:0]      gen_data;
  logic             new_req, start, busy, busy_next, done, kill_now;

  dbus_strobe_gen u_strobe (
    .size    (mem_size),
    .addr_lo (mem_addr[1:0]),
    .wr      (mem_wr),
    .wdata   (mem_wdata),
    .strobe  (gen_strobe),
    .data    (gen_data)
  );

  assign misalign  = mem_en & is_misaligned(mem_size, mem_addr[1:0]);
  assign new_req   = mem_en & ~flush & ~misalign;
  assign start     = (state == IDLE) & new_req;
  assign busy      = (state == REQ) | (state == WAIT);
  assign done      = ((state == REQ) & dresp.addr_ok & dresp.data_ok) |
                     ((state == WAIT) & dresp.data_ok);
  assign kill_now  = kill | flush;
  assign busy_next = start | (busy & ~done);

  // A killed transaction releases the pipeline, but a fresh M-stage access
  // must still be held off until the bus is free again.
  assign stall_mem = ((state == IDLE) & new_req) | (busy & ~kill) | (busy & kill & new_req);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      dreq  <= '0;
      rdata <= '0;
      kill  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= REQ;
            dreq.valid  <= 1'b1;
            dreq.addr   <= mem_addr;
            dreq.size   <= mem_size;
            dreq.strobe <= gen_strobe;
            dreq.data   <= gen_data;
          end
        end
        REQ: begin
          if (flush) kill <= 1'b1;
          if (dresp.addr_ok) begin
            dreq.valid <= 1'b0;
            if (dresp.data_ok) begin
              state <= kill_now ? IDLE : HOLD;
              kill  <= 1'b0;
              if (!kill_now) rdata <= dresp.data;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (flush) kill <= 1'b1;
          if (dresp.data_ok) begin
            state <= kill_now ? IDLE : HOLD;
            kill  <= 1'b0;
            if (!kill_now) rdata <= dresp.data;
          end
        end
        HOLD: begin
          if (advance | flush) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // tmo_cnt holds the number of REQ/WAIT cycles including the current one,
  // saturating at the limit so the debug pulse fires only once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
    end else if (busy_next) begin
      if (tmo_cnt != TMO_LIMIT) tmo_cnt <= tmo_cnt + CNT_W'(1);
      err_timeout <= (TIMEOUT_CYC > 0) && (tmo_cnt != TMO_LIMIT) &&
                     (tmo_cnt + CNT_W'(1) == TMO_LIMIT);
    end else begin
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dbus_ctrl.sv
`default_nettype none
//==============================================================================
// tb_dbus_ctrl: randomized scoreboard bench for dbus_ctrl with a bus responder.
// Rev 1.0
//==============================================================================
module tb_dbus_ctrl;
  import dbus_ctrl_pkg::*;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_en, mem_wr, advance, flush;
  logic [31:0] mem_addr, mem_wdata;
  msize_t      mem_size;
  dbus_req_t   dreq;
  dbus_resp_t  dresp;
  logic        stall_mem, misalign, err_timeout;
  logic [31:0] rdata;

  dbus_ctrl #(.TIMEOUT_CYC(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_en      (mem_en),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_size    (mem_size),
    .mem_wdata   (mem_wdata),
    .advance     (advance),
    .flush       (flush),
    .dreq        (dreq),
    .dresp       (dresp),
    .stall_mem   (stall_mem),
    .rdata       (rdata),
    .misalign    (misalign),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
    int          vcyc;
  } exp_req_t;

  typedef struct {
    int          a;
    int          d;
    logic [31:0] data;
  } plan_t;

  exp_req_t    exp_q[$];
  plan_t       plan_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_rdata = '0;
  int          busy_until = -10;
  bit          tmo_window = 1'b0;
  bit          err_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: byte count, alignment, lane selection, lane contents.
  function automatic int nbytes(input msize_t s);
    case (s)
      MSIZE1:  return 1;
      MSIZE2:  return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit model_mis(input logic [31:0] addr, input msize_t s);
    return (int'(addr[1:0]) % nbytes(s)) != 0;
  endfunction

  function automatic logic [3:0] model_strobe(input bit wr, input logic [31:0] addr, input msize_t s);
    int off = int'(addr[1:0]);
    int n   = nbytes(s);
    logic [3:0] st = '0;
    if (wr)
      for (int i = 0; i < 4; i++)
        if (i >= off && i < off + n) st[i] = 1'b1;
    return st;
  endfunction

  function automatic logic [31:0] model_data(input logic [31:0] wdata, input msize_t s);
    int n = nbytes(s);
    logic [31:0] dd;
    for (int i = 0; i < 4; i++) dd[8*i +: 8] = wdata[8*(i % n) +: 8];
    return dd;
  endfunction

  // Monitor: every new request must match the next scoreboard entry.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    exp_req_t e;
    if (reset) begin
      prev_valid <= 1'b0;
    end else begin
      if (dreq.valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_request", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("req_addr", dreq.addr, e.addr);
          check("req_size", 32'(dreq.size), 32'(e.size));
          check("req_strobe", 32'(dreq.strobe), 32'(e.strobe));
          check("req_data", dreq.data, e.data);
          check("req_cycle", cyc, e.vcyc);
        end
      end
      prev_valid <= dreq.valid;
      if (err_timeout && !tmo_window) err_seen <= 1'b1;
    end
  end

  // Bus responder: serves each request per its plan (addr_ok delay, data_ok delay).
  initial begin
    plan_t cur;
    int    phase = 0;
    int    cnt = 0;
    dresp = '0;
    forever begin
      @(negedge clk);
      dresp.addr_ok = 1'b0;
      dresp.data_ok = 1'b0;
      dresp.data    = $urandom;
      if (phase == 0 && dreq.valid && plan_q.size() > 0) begin
        cur   = plan_q.pop_front();
        cnt   = cur.a;
        phase = 1;
      end
      if (phase == 1) begin
        if (cnt == 0) begin
          dresp.addr_ok = 1'b1;
          if (cur.d == 0) begin
            dresp.data_ok = 1'b1;
            dresp.data    = cur.data;
            phase         = 0;
          end else begin
            cnt   = cur.d;
            phase = 2;
          end
        end else begin
          cnt--;
        end
      end else if (phase == 2) begin
        cnt--;
        if (cnt == 0) begin
          dresp.data_ok = 1'b1;
          dresp.data    = cur.data;
          phase         = 0;
        end
      end
    end
  end

  // One M-stage access. kf >= 0 flushes it kf cycles into the transaction.
  task automatic do_op(input bit wr, input logic [31:0] addr, input msize_t size,
                       input logic [31:0] wdata, input int a, input int d, input int kf,
                       input int hold, input bit hflush, input logic [31:0] rdat);
    int tn, ts, td, tf;
    bit stall_ok, hold_ok;
    exp_req_t e;
    plan_t p;
    @(posedge clk); #1;
    mem_en = 1'b1; mem_wr = wr; mem_addr = addr; mem_size = size; mem_wdata = wdata;
    flush = 1'b0; advance = 1'b0;
    tn = cyc;
    @(negedge clk);
    check("misalign", 32'(misalign), 32'(model_mis(addr, size)));
    if (model_mis(addr, size)) begin
      check("stall_on_misalign", 32'(stall_mem), 32'd0);
      @(posedge clk); #1;
      mem_en = 1'b0;
      return;
    end
    ts = (busy_until + 1 > tn) ? busy_until + 1 : tn;
    td = ts + 1 + a + d;
    p.a = a; p.d = d; p.data = rdat;
    plan_q.push_back(p);
    e.addr = addr; e.size = size; e.strobe = model_strobe(wr, addr, size);
    e.data = model_data(wdata, size); e.vcyc = ts + 1;
    exp_q.push_back(e);
    stall_ok = stall_mem;
    if (kf >= 0) begin
      tf = ts + 1 + kf;
      for (int c = tn + 1; c <= tf + 1; c++) begin
        @(posedge clk); #1;
        flush = (c == tf);
        if (c == tf + 1) mem_en = 1'b0;
        @(negedge clk);
        if (c <= tf) begin
          if (!stall_mem) stall_ok = 1'b0;
        end else begin
          check("stall_drop_after_flush", 32'(stall_mem), 32'd0);
          check("rdata_kept_on_kill", rdata, exp_rdata);
        end
      end
      check("stall_before_flush", 32'(stall_ok), 32'd1);
      busy_until = td;
    end else begin
      hold_ok = 1'b1;
      for (int c = tn + 1; c <= td + 1 + hold; c++) begin
        @(posedge clk); #1;
        if (c == td + 1 + hold) begin
          advance = hflush ? 1'($urandom_range(0, 1)) : 1'b1;
          flush   = hflush;
        end
        @(negedge clk);
        if (c <= td) begin
          if (!stall_mem) stall_ok = 1'b0;
        end else if (c == td + 1) begin
          check("stall_while_busy", 32'(stall_ok), 32'd1);
          check("stall_in_hold", 32'(stall_mem), 32'd0);
          check("rdata", rdata, rdat);
        end else if (stall_mem || rdata !== rdat) begin
          hold_ok = 1'b0;
        end
      end
      if (hold > 0) check("hold_stable", 32'(hold_ok), 32'd1);
      exp_rdata = rdat;
    end
    @(posedge clk); #1;
    mem_en = 1'b0; flush = 1'b0; advance = 1'b0;
  endtask

  initial begin
    msize_t      sz;
    logic [31:0] ad;
    int          n, a_r, d_r, kf, tn, pulses, pcyc;
    reset = 1'b1;
    mem_en = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_size = MSIZE4; mem_wdata = '0;
    advance = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 32'(dreq.valid), 32'd0);
    check("reset_stall", 32'(stall_mem), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_err_timeout", 32'(err_timeout), 32'd0);
    check("reset_misalign", 32'(misalign), 32'd0);
    reset = 1'b0;

    do_op(1'b0, 32'h100, MSIZE4, 32'h0, 1, 0, -1, 0, 1'b0, 32'hDEADBEEF);
    do_op(1'b1, 32'h103, MSIZE1, 32'h000000AB, 0, 1, -1, 1, 1'b0, 32'h11112222);
    do_op(1'b0, 32'h102, MSIZE2, 32'h0, 0, 5, -1, 0, 1'b0, 32'h0000BEEF);
    do_op(1'b0, 32'h104, MSIZE4, 32'h0, 0, 6, 3, 0, 1'b0, 32'hBAD0BAD0);
    do_op(1'b1, 32'h108, MSIZE4, 32'h12345678, 1, 1, -1, 2, 1'b0, 32'hCAFEF00D);
    do_op(1'b0, 32'h102, MSIZE4, 32'h0, 0, 0, -1, 0, 1'b0, 32'h0);

    repeat (150) begin
      sz = msize_t'($urandom_range(0, 2));
      n  = nbytes(sz);
      ad = $urandom;
      if (n == 4) ad[1:0] = 2'b00;
      if (n == 2) ad[0] = 1'b0;
      if (n > 1 && $urandom_range(0, 9) == 0) ad[0] = 1'b1;
      a_r = $urandom_range(0, 3);
      d_r = $urandom_range(0, 3);
      kf  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, a_r + d_r)) : -1;
      do_op(1'($urandom_range(0, 1)), ad, sz, $urandom, a_r, d_r, kf,
            $urandom_range(0, 2), ($urandom_range(0, 3) == 0), $urandom);
    end

    repeat (12) @(posedge clk);
    check("req_queue_drained", exp_q.size(), 32'd0);
    check("plan_queue_drained", plan_q.size(), 32'd0);
    check("no_spurious_timeout", 32'(err_seen), 32'd0);

    // Address phase never acknowledged: debug pulse, then reset recovery.
    @(posedge clk); #1;
    tmo_window = 1'b1;
    mem_en = 1'b1; mem_wr = 1'b0; mem_addr = 32'h200; mem_size = MSIZE4;
    tn = cyc;
    begin
      plan_t    p;
      exp_req_t e;
      p.a = 40; p.d = 0; p.data = '0;
      plan_q.push_back(p);
      e.addr = 32'h200; e.size = MSIZE4; e.strobe = 4'h0;
      e.data = model_data(mem_wdata, MSIZE4); e.vcyc = tn + 1;
      exp_q.push_back(e);
    end
    pulses = 0; pcyc = -1;
    @(negedge clk);
    for (int c = tn + 1; c <= tn + 12; c++) begin
      @(negedge clk);
      if (err_timeout) begin
        pulses++;
        pcyc = c - tn;
      end
    end
    check("timeout_pulses", pulses, 32'd1);
    check("timeout_req_cycle", pcyc, 32'd8);
    check("valid_held_after_timeout", 32'(dreq.valid), 32'd1);
    #2;
    reset = 1'b1; mem_en = 1'b0;
    #1;
    check("reset_mid_txn_valid", 32'(dreq.valid), 32'd0);
    check("reset_mid_txn_stall", 32'(stall_mem), 32'd0);
    check("reset_mid_txn_err", 32'(err_timeout), 32'd0);
    plan_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
